// File: rtl/a1csa_32bits.sv
// Registered carry-select adder: 4-bit ripple blocks, with an add-one circuit in each
// upper block that derives the carry-in-1 result from the carry-in-0 sum.
module a1csa_32bits #(
  parameter int n   = 32,
  parameter int BLK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cin,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] s,
  output logic         cout
);

  localparam int NB = n / BLK;

  logic [NB:0]  blk_c;
  logic [n-1:0] sum_d;
  logic         cout_d;
  logic [n-1:0] s_q;
  logic         cout_q;

  assign blk_c[0] = cin;

  genvar gi, gj;
  for (gi = 0; gi < NB; gi++) begin : g_blk
    logic [BLK:0]   rc;
    logic [BLK-1:0] s0;

    // Only block 0 sees the real carry-in; upper blocks ripple from 0.
    assign rc[0] = (gi == 0) ? cin : 1'b0;

    for (gj = 0; gj < BLK; gj++) begin : g_fa
      assign s0[gj]    = a[gi*BLK+gj] ^ b[gi*BLK+gj] ^ rc[gj];
      assign rc[gj+1]  = (a[gi*BLK+gj] & b[gi*BLK+gj]) |
                         (rc[gj] & (a[gi*BLK+gj] ^ b[gi*BLK+gj]));
    end

    if (gi == 0) begin : g_rca
      assign sum_d[BLK-1:0] = s0;
      assign blk_c[1]       = rc[BLK];
    end else begin : g_csa
      logic [BLK:0]   ones;
      logic [BLK-1:0] s1;
      logic           c1;

      assign ones[0] = 1'b1;
      for (gj = 0; gj < BLK; gj++) begin : g_inc
        assign ones[gj+1] = ones[gj] & s0[gj];
        assign s1[gj]     = s0[gj] ^ ones[gj];
      end
      assign c1 = rc[BLK] | ones[BLK];

      assign sum_d[gi*BLK +: BLK] = blk_c[gi] ? s1 : s0;
      assign blk_c[gi+1]          = blk_c[gi] ? c1 : rc[BLK];
    end
  end

  assign cout_d = blk_c[NB];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_a1csa_32bits.sv
// Directed and back-to-back random checks of the registered 32-bit carry-select adder.
module tb_a1csa_32bits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cin;
  logic [31:0] a, b;
  logic [31:0] s;
  logic        cout;

  int n_checks = 0;
  int n_fail   = 0;

  a1csa_32bits #(.n(32), .BLK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cin  (cin),
    .a    (a),
    .b    (b),
    .s    (s),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {cout,s}=%h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one vector after the falling edge, check one cycle later.
  task automatic apply(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic [32:0] exp);
    @(negedge clk);
    a = va; b = vb; cin = vc;
    @(posedge clk);
    #1;
    $display("txn %s a=%h b=%h cin=%b -> cout=%b s=%h", tag, va, vb, vc, cout, s);
    check(tag, {cout, s}, exp);
  endtask

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vc;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [32:0] hold_val;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] rexp;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000};
    vecs[1] = '{32'h0000000F, 32'h00000001, 1'b0, 33'h0_00000010};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000};
    vecs[3] = '{32'h12345678, 32'h87654321, 1'b1, 33'h0_9999999A};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF};
    vecs[5] = '{32'h0000000F, 32'h00000000, 1'b1, 33'h0_00000010};
    vecs[6] = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 33'h0_10000000};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 33'h0_00000001};
    vecs[8] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 33'h0_80000000};
    vecs[9] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 33'h1_00000000};

    // Reset with the worst-case inputs must still clear the outputs.
    rst_n = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
    @(posedge clk); #1;
    $display("txn reset a=%h b=%h cin=%b -> cout=%b s=%h", a, b, cin, cout, s);
    check("reset", {cout, s}, 33'h0);

    // First edge with rst_n high computes from the inputs present at that edge.
    @(negedge clk);
    rst_n = 1'b1; a = 32'h12345678; b = 32'h87654321; cin = 1'b1;
    @(posedge clk); #1;
    $display("txn first a=%h b=%h cin=%b -> cout=%b s=%h", a, b, cin, cout, s);
    check("first_after_reset", {cout, s}, 33'h0_9999999A);

    foreach (vecs[i])
      apply($sformatf("dir%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].exp);

    // Outputs hold while inputs change between edges.
    hold_val = 33'h1_00000000;
    @(negedge clk);
    a = 32'h00000001; b = 32'h00000002; cin = 1'b0;
    #2;
    check("hold_between_edges", {cout, s}, hold_val);

    // Reset asserted between edges has no effect until the next edge.
    rst_n = 1'b0;
    #1;
    check("reset_not_async", {cout, s}, hold_val);
    @(posedge clk); #1;
    $display("txn midreset a=%h b=%h cin=%b -> cout=%b s=%h", a, b, cin, cout, s);
    check("reset_midstream", {cout, s}, 33'h0);

    @(negedge clk);
    rst_n = 1'b1;
    apply("after_midreset", 32'h00000001, 32'h00000002, 1'b0, 33'h0_00000003);

    // Back-to-back random vectors, one per cycle; only mismatches are reported.
    for (int i = 0; i < 30000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      @(negedge clk);
      a = ra; b = rb; cin = rc;
      @(posedge clk); #1;
      check($sformatf("rand%0d", i), {cout, s}, rexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a1csa_32bits.md
A1CSA_32BITS -- requirements
Module: a1csa_32bits

Interface
REQ-001: Parameter n, default 32, operand width; n SHALL be a multiple of 4 and at least 8.
REQ-002: Parameter BLK, default 4, carry-select block width; fixed at 4 in this revision.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, synchronous and active-low.
REQ-005: cin  input  1  carry-in of the addition.
REQ-006: a  input  n  first unsigned operand.
REQ-007: b  input  n  second unsigned operand.
REQ-008: s  output  n  registered sum, a+b+cin modulo 2^n.
REQ-009: cout  output  1  registered carry-out, bit n of a+b+cin.
REQ-010: The block SHALL have no propagate/generate outputs.

Function
REQ-011: Core arithmetic SHALL be combinational and exact: {cout,s} = a + b + cin, full (n+1)-bit result, no truncation except modulo 2^n on s.
REQ-012: Block 0 (bits 3:0) SHALL be a 4-bit ripple-carry adder fed directly by cin.
REQ-013: Each higher 4-bit block k SHALL compute s0_k and c0_k with a ripple-carry adder at carry-in 0.
REQ-014: Each higher block SHALL derive the carry-in-1 result with an add-one circuit, not a second adder.
REQ-015: Add-one rule: s1_k = s0_k + 1 via incrementer chain (bit i toggles when all lower bits of s0_k are 1); c1_k = c0_k OR (s0_k all ones).
REQ-016: A 2:1 mux per block SHALL select {c1_k,s1_k} when the carry out of block k-1 is 1, else {c0_k,s0_k}.
REQ-017: Block carries SHALL chain through the muxes only; cout = carry out of the top block.
REQ-018: Carry across every block boundary SHALL be correct, including a carry rippling through all blocks (all-ones propagate).
REQ-019: s and cout SHALL be registered on the rising edge of clk.
REQ-020: Latency SHALL be exactly 1 cycle: inputs sampled at edge t appear on s/cout after edge t.
REQ-021: Throughput SHALL be one new operation per cycle; there is no handshake or stall.
REQ-022: Outputs SHALL hold their value between edges; input changes between edges SHALL not affect outputs until the next edge.
REQ-023: Results SHALL be identical for cin=0 and cin=1 paths to a behavioural a+b+cin reference for every input combination.

Reset
REQ-024: When rst_n=0 at a rising edge, s SHALL become 0 and cout SHALL become 0, regardless of a, b and cin.
REQ-025: Reset SHALL have no asynchronous effect; asserting rst_n between edges SHALL not change outputs before the next edge.
REQ-026: The first result SHALL appear at the first edge with rst_n=1, computed from the inputs present at that edge.
REQ-027: Reset asserted mid-stream SHALL discard the in-flight result; the block holds no other state.

Verification
REQ-028: rst_n=0, a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1, one edge -> s=0x00000000, cout=0.
REQ-029: a=0xFFFFFFFF, b=0x00000000, cin=1 -> next cycle s=0x00000000, cout=1 (full-chain carry through every add-one block).
REQ-030: a=0x0000000F, b=0x00000001, cin=0 -> s=0x00000010, cout=0 (carry across block boundary 0/1).
REQ-031: a=0x80000000, b=0x80000000, cin=0 -> s=0x00000000, cout=1.
REQ-032: a=0x12345678, b=0x87654321, cin=1 -> s=0x9999999A, cout=0.
REQ-033: 30000 random {cin,a,b} vectors applied back-to-back, one per cycle -> each {cout,s} equals a+b+cin of the previous cycle with zero mismatches; the bench logs each mismatch and reports the total at end.
